// File: rtl/acc_to_bf16_pipe.sv
// acc_to_bf16_pipe: multi-lane, three-stage pipelined converter from signed
// fixed-point accumulator words (ACC_W bits, FRAC_BITS fraction bits) to BF16.
// Stage 1: sign, magnitude, leading-zero count.
// Stage 2: normalise, exponent, mantissa/guard/sticky extraction.
// Stage 3: assemble BF16 word and inexact flag.
// Optional feature macro: ACC_BF16_RNE_EN.
//   Defined:   round-to-nearest-even in stage 3.
//   Undefined: truncation.
//
// Valid/ready: a beat crosses any boundary (input, S1->S2, S2->S3, output)
// on a rising edge where the producer's valid and the consumer's ready are
// both high. A stage register loads when it is empty or when its own
// content moves on in the same edge. Ready therefore ripples back from
// out_ready through the stage valid flags only. Data never feeds a ready.
module acc_to_bf16_pipe #(
  parameter int ACC_W     = 18,
  parameter int FRAC_BITS = 8,
  parameter int LANES     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*16-1:0]      out_bf16,
  output logic [LANES-1:0]         out_inexact
);

  localparam int LZ_W   = $clog2(ACC_W + 1);
  // Exponent when the leading one sits at bit ACC_W-1 (lz = 0).
  localparam int E_BIAS = ACC_W - 1 - FRAC_BITS + 127;

  // Two-level leading-zero detector: per-nibble zero flags and local counts,
  // then a priority pick over the nibbles. The value is left-aligned into a
  // 32-bit word so the nibble grid is fixed for every legal ACC_W.
  function automatic logic [LZ_W-1:0] lzc(input logic [ACC_W-1:0] mag);
    logic [31:0]     x;
    logic [7:0]      nz;
    logic [7:0][1:0] sub;
    logic [5:0]      r;
    logic            found;
    x = 32'(mag) << (32 - ACC_W);
    for (int g = 0; g < 8; g++) begin
      nz[g]  = |x[g*4 +: 4];
      sub[g] = x[g*4+3] ? 2'd0 :
               x[g*4+2] ? 2'd1 :
               x[g*4+1] ? 2'd2 : 2'd3;
    end
    r     = 6'd0;
    found = 1'b0;
    for (int g = 7; g >= 0; g--) begin
      if (!found && nz[g]) begin
        r     = {1'b0, 3'(7 - g), sub[g]};
        found = 1'b1;
      end
    end
    return (mag == '0) ? LZ_W'(ACC_W) : LZ_W'(r);
  endfunction

  // Pipeline control
  logic rst_done;
  logic v1, v2, v3;
  logic load1, load2, load3;

  // Stage 1 registers and next values
  logic [LANES-1:0]            s1_sign_d, s1_sign;
  logic [LANES-1:0][ACC_W-1:0] s1_mag_d, s1_mag;
  logic [LANES-1:0][LZ_W-1:0]  s1_lz_d, s1_lz;

  // Stage 2 registers and next values
  logic [LANES-1:0][ACC_W+7:0] ext;
  logic [LANES-1:0]            s2_sign_d, s2_sign;
  logic [LANES-1:0]            s2_zero_d, s2_zero;
  logic [LANES-1:0][7:0]       s2_e_d, s2_e;
  logic [LANES-1:0][6:0]       s2_m_d, s2_m;
  logic [LANES-1:0]            s2_g_d, s2_g;
  logic [LANES-1:0]            s2_s_d, s2_s;

  // Stage 3 next values (the output registers are out_bf16/out_inexact)
  logic [LANES-1:0][15:0]      s3_bf_d;
  logic [LANES-1:0]            s3_inexact_d;
`ifdef ACC_BF16_RNE_EN
  logic [LANES-1:0]            rnd_inc;
  logic [LANES-1:0][7:0]       rnd_sum;
`endif

  // Stage load enables: a register loads when empty or when it drains
  always_comb begin
    load3    = !v3 || out_ready;
    load2    = !v2 || load3;
    load1    = rst_done && (!v1 || load2);
    in_ready = load1;
  end

  // Valid flags; rst_done holds in_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (load1) v1 <= in_valid;
      if (load2) v2 <= v1;
      if (load3) v3 <= v2;
    end
  end

  assign out_valid = v3;

  // Stage 1 combinational: sign, magnitude and leading-zero count per lane
  always_comb begin
    s1_sign_d = '0;
    s1_mag_d  = '0;
    s1_lz_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_sign_d[i] = in_acc[i*ACC_W + ACC_W - 1];
      s1_mag_d[i]  = s1_sign_d[i] ? (~in_acc[i*ACC_W +: ACC_W]) + ACC_W'(1)
                                  : in_acc[i*ACC_W +: ACC_W];
      s1_lz_d[i]   = lzc(s1_mag_d[i]);
    end
  end

  // Stage 1 data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign <= '0;
      s1_mag  <= '0;
      s1_lz   <= '0;
    end else if (load1) begin
      s1_sign <= s1_sign_d;
      s1_mag  <= s1_mag_d;
      s1_lz   <= s1_lz_d;
    end
  end

  // Stage 2 combinational: normalise and split mantissa/guard/sticky.
  // ext holds the bits below the leading one followed by nine zeros, so
  // mantissa, guard and sticky always exist even for small ACC_W.
  // The exponent lies in 96..159, so its low 8 bits are exact modulo 256.
  always_comb begin
    ext       = '0;
    s2_sign_d = '0;
    s2_zero_d = '0;
    s2_e_d    = '0;
    s2_m_d    = '0;
    s2_g_d    = '0;
    s2_s_d    = '0;
    for (int i = 0; i < LANES; i++) begin
      ext[i]       = {(ACC_W-1)'(s1_mag[i] << s1_lz[i]), 9'd0};
      s2_sign_d[i] = s1_sign[i];
      s2_zero_d[i] = (s1_mag[i] == '0);
      s2_e_d[i]    = 8'(E_BIAS) - 8'(s1_lz[i]);
      s2_m_d[i]    = ext[i][ACC_W+7 -: 7];
      s2_g_d[i]    = ext[i][ACC_W];
      s2_s_d[i]    = |ext[i][ACC_W-1:0];
    end
  end

  // Stage 2 data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sign <= '0;
      s2_zero <= '0;
      s2_e    <= '0;
      s2_m    <= '0;
      s2_g    <= '0;
      s2_s    <= '0;
    end else if (load2) begin
      s2_sign <= s2_sign_d;
      s2_zero <= s2_zero_d;
      s2_e    <= s2_e_d;
      s2_m    <= s2_m_d;
      s2_g    <= s2_g_d;
      s2_s    <= s2_s_d;
    end
  end

  // Stage 3 combinational: rounding (optional) and BF16 assembly
  always_comb begin
    s3_bf_d      = '0;
    s3_inexact_d = '0;
`ifdef ACC_BF16_RNE_EN
    rnd_inc      = '0;
    rnd_sum      = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      s3_inexact_d[i] = s2_g[i] | s2_s[i];
`ifdef ACC_BF16_RNE_EN
      rnd_inc[i] = s2_g[i] & (s2_s[i] | s2_m[i][0]);
      rnd_sum[i] = {1'b0, s2_m[i]} + {7'd0, rnd_inc[i]};
      // A carry out of the mantissa leaves it zero and bumps the exponent
      if (!s2_zero[i])
        s3_bf_d[i] = {s2_sign[i], s2_e[i] + {7'd0, rnd_sum[i][7]}, rnd_sum[i][6:0]};
`else
      if (!s2_zero[i])
        s3_bf_d[i] = {s2_sign[i], s2_e[i], s2_m[i]};
`endif
    end
  end

  // Output registers; held while out_valid && !out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_bf16    <= '0;
      out_inexact <= '0;
    end else if (load3) begin
      out_bf16    <= s3_bf_d;
      out_inexact <= s3_inexact_d;
    end
  end

endmodule

// File: doc/acc_to_bf16_pipe.md
# acc_to_bf16_pipe

Multi-lane, pipelined converter from signed fixed-point accumulator words to BF16. It sits between the systolic array's accumulator drain and the BF16 output/writeback path. It generalises the combinational INT18-to-BF16 normaliser in three ways:
- parametrised accumulator width and fraction bits;
- `LANES` parallel channels;
- a three-stage valid/ready pipeline with optional round-to-nearest-even and a per-lane inexact flag.

## Interface
Parameters:
- `ACC_W`, 18, accumulator width in bits, two's complement; legal range 8..32.
- `FRAC_BITS`, 8, binary point position; legal range 0..`ACC_W`-1.
- `LANES`, 4, number of parallel conversion lanes; legal range ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_acc`  in  `LANES`*`ACC_W`  packed accumulators; lane i occupies `[i*ACC_W +: ACC_W]`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_bf16`  out  `LANES`*16  packed BF16 results; lane i occupies `[i*16 +: 16]`.
- `out_inexact`  out  `LANES`  per lane: nonzero bits were discarded during conversion.

## Operation
- One beat transfers when `valid && ready` on a rising edge. All lanes travel together in one beat.
- Stage S1, per lane:
  - sign = msb of the accumulator.
  - mag = |acc| as an unsigned `ACC_W`-bit value. The most negative input gives mag = 2^(`ACC_W`-1), which fits.
  - lz = leading-zero count of mag. A hierarchical detector is used; mag = 0 gives lz = `ACC_W`.
- Stage S2, per lane:
  - norm = mag << lz.
  - e = (`ACC_W`-1-lz) - `FRAC_BITS` + 127, computed signed and at least 10 bits wide.
  - m = the 7 bits of norm directly below the leading one.
  - g = the next bit below m.
  - s = OR of all remaining lower bits.
  - Any bit positions missing because `ACC_W` is small are read as 0.
- Stage S3, per lane, assembles {sign, e[7:0], m}. Rounding follows the Configuration section.
  - If rounding carries out of the mantissa: m = 0 and e = e+1.
- mag = 0 produces 16'h0000 and inexact = 0. There is no negative zero.
- Exponent range: with the legal parameter range, e stays within 96..159. Overflow, underflow and subnormal results cannot occur, so no saturation logic is required.
- `out_inexact` = g | s for each lane, independent of the rounding mode.
- Pipeline control:
  - Each stage k has a valid flag vk.
  - Stage k advances when !v(k+1) or stage k+1 advances; stage S3 advances when `out_ready` or !v3.
  - `in_ready` = !v1 or S1 advances.
  - Bubbles collapse. Beat order is preserved. No beat is dropped or duplicated.
- Data registers load only on advance and hold their value while stalled.

## Timing
- Latency: 3 cycles from input acceptance to `out_valid` when not stalled.
- Throughput: 1 beat per cycle while `out_ready` = 1.
- `in_ready` depends combinationally on `out_ready`, through the stage valid flags only. There is no combinational path from data inputs to any output.
- Under full backpressure the pipeline holds 3 beats. `in_ready` falls in the cycle after the third unconsumed beat is accepted.
- The stall/ready rule also covers simultaneous accept-in and drain-out in a full pipeline: both transfers occur, with no bubble.
- Reset, at any time including mid-stream, drives all of the following to 0 immediately:
  - all valid flags, `out_valid`, `in_ready`, `out_bf16`, `out_inexact`;
  - all data registers.
  
  In-flight beats are discarded. `in_ready` = 1 from the first edge after `rst` deasserts.
- Output values are stable while `out_valid` && !`out_ready`.

## Configuration
- `ACC_BF16_RNE_EN`, a preprocessor macro:
  - Defined: round-to-nearest-even. Increment m when g && (s || m[0]).
  - Undefined: truncation. m is used unchanged, which is bit-compatible with the previous normaliser, and the S3 incrementer is compiled out.
- `out_inexact` is present in both builds.

## Test plan
All scenarios use default parameters (`ACC_W`=18, `FRAC_BITS`=8, `LANES`=4).
- Lanes {256, -256, 0, -131072} -> {16'h3F80, 16'hBF80, 16'h0000, 16'hC400}; inexact 4'b0000; `out_valid` exactly 3 cycles after accept.
- Lane 131071 -> 16'h4400 with `ACC_BF16_RNE_EN` defined, 16'h43FF without it; inexact = 1 in both builds.
- Ties: 257 -> 16'h3F80 in both builds. 259 -> 16'h3F82 with RNE, 16'h3F81 without. inexact = 1 for both inputs.
- Backpressure: drive a continuous random stream with `out_ready` low for 5 cycles.
  - Expect exactly 3 beats accepted, then `in_ready` = 0 and `out_bf16` stable.
  - On release, all beats emerge in order and match the reference model.
  - Random `out_ready` toggling over 10k beats produces zero mismatches.
- Reset mid-stream: assert `rst` with 2 beats in flight.
  - Outputs and valids go to 0 without waiting for a clock edge.
  - After release, no stale beat appears and the first new beat converts correctly.
